// File: rtl/picosoc_iomem_pkg.sv
// picosoc_iomem_pkg: shared state encoding, bus widths and defaults for the iomem arbiter slice.
package picosoc_iomem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 8;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/iomem_watchdog.sv
// iomem_watchdog: counts slave wait cycles of one transfer and flags the cycle it runs out.
module iomem_watchdog
    import picosoc_iomem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic tick,
    input  logic ack,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || start)
            cnt <= '0;
        else if (tick && !ack)
            cnt <= cnt + CNT_W'(1);
    end

    // a slave ack in the last allowed cycle wins over the timeout
    assign expire = tick && !ack && (cnt == LIMIT);

endmodule

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: round-robin two-master arbiter onto one iomem slave with a transfer watchdog.
module iomem_arbiter
    import picosoc_iomem_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    output logic [STRB_W-1:0] s_wstrb,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              timeout_err,
    input  logic              err_clr
);

    arb_state_t state;
    logic grant;
    logic last;
    logic any_valid;
    logic win;
    logic g_valid;
    logic busy;
    logic expire;
    logic done;
    logic [DATA_W-1:0] rsel;

    assign any_valid = m0_valid | m1_valid;
    assign win       = (m0_valid && m1_valid) ? ~last : m1_valid;
    assign g_valid   = grant ? m1_valid : m0_valid;
    // outputs are masked while resetn is low so a reset aborts without a pulse
    assign busy      = resetn && (state == BUSY);
    assign done      = busy && g_valid && (s_ready || expire);
    assign rsel      = expire ? ERR_DATA : s_rdata;

    assign s_valid  = busy;
    assign s_wstrb  = grant ? m1_wstrb : m0_wstrb;
    assign s_addr   = grant ? m1_addr  : m0_addr;
    assign s_wdata  = grant ? m1_wdata : m0_wdata;
    assign m0_ready = done && !grant;
    assign m1_ready = done && grant;
    assign m0_rdata = m0_ready ? rsel : '0;
    assign m1_rdata = m1_ready ? rsel : '0;

    iomem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .start  ((state == IDLE) && any_valid),
        .tick   ((state == BUSY) && g_valid),
        .ack    (s_ready),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last        <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_valid) begin
                    state <= BUSY;
                    grant <= win;
                    last  <= win;
                end
                BUSY: if (!g_valid || s_ready || expire) state <= DONE;
                default: state <= IDLE;
            endcase
            timeout_err <= expire ? 1'b1 : err_clr ? 1'b0 : timeout_err;
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// tb_iomem_arbiter: directed checks of arbitration, completion, timeout and reset behaviour.
module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        timeout_err;
    logic        err_clr;

    int total  = 0;
    int passed = 0;

    iomem_arbiter dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        resetn = 0; m0_valid = 0; m1_valid = 0; m0_wstrb = 0; m1_wstrb = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        s_ready = 0; s_rdata = 0; err_clr = 0;
        step(); step();
        chk("rst_svalid", 32'(s_valid), 0);
        chk("rst_m0_ready", 32'(m0_ready), 0);
        chk("rst_m1_ready", 32'(m1_ready), 0);
        chk("rst_terr", 32'(timeout_err), 0);

        // simple read, slave ready in third BUSY cycle
        resetn = 1; m0_valid = 1; m0_addr = 32'h0300_0000; m0_wstrb = 0;
        #1 chk("idle_svalid", 32'(s_valid), 0);
        step();
        chk("rd_svalid", 32'(s_valid), 1);
        chk("rd_saddr", s_addr, 32'h0300_0000);
        chk("rd_swstrb", 32'(s_wstrb), 0);
        chk("rd_wait_ready", 32'(m0_ready), 0);
        step();
        step();
        s_ready = 1; s_rdata = 32'h0000_00A5;
        #1 chk("rd_ready", 32'(m0_ready), 1);
        chk("rd_rdata", m0_rdata, 32'h0000_00A5);
        chk("rd_m1_ready", 32'(m1_ready), 0);
        chk("rd_m1_rdata", m1_rdata, 0);
        step();
        s_ready = 0;
        #1 chk("done_svalid", 32'(s_valid), 0);
        chk("done_ready", 32'(m0_ready), 0);
        m0_valid = 0;
        step();
        chk("back_idle", 32'(s_valid), 0);

        // tie after reset: m0, then m1, then m0 again
        resetn = 0; step(); resetn = 1;
        m0_valid = 1; m0_addr = 32'h0300_0010;
        m1_valid = 1; m1_addr = 32'h0300_0020; m1_wstrb = 4'hF; m1_wdata = 32'hCAFE_0001;
        step();
        chk("tie1_addr", s_addr, 32'h0300_0010);
        s_ready = 1; s_rdata = 32'h1111_1111;
        #1 chk("tie1_m0_ready", 32'(m0_ready), 1);
        chk("tie1_m1_ready", 32'(m1_ready), 0);
        chk("tie1_m1_rdata", m1_rdata, 0);
        step();
        s_ready = 0; m0_valid = 0;
        #1 chk("tie1_done", 32'(s_valid), 0);
        step();
        step();
        chk("tie2_addr", s_addr, 32'h0300_0020);
        chk("tie2_wstrb", 32'(s_wstrb), 32'hF);
        chk("tie2_wdata", s_wdata, 32'hCAFE_0001);
        m0_valid = 1; s_ready = 1; s_rdata = 32'h2222_2222;
        #1 chk("tie2_m1_ready", 32'(m1_ready), 1);
        chk("tie2_m1_rdata", m1_rdata, 32'h2222_2222);
        chk("tie2_m0_ready", 32'(m0_ready), 0);
        chk("tie2_m0_rdata", m0_rdata, 0);
        step();
        s_ready = 0;
        step();
        step();
        chk("tie3_addr", s_addr, 32'h0300_0010);
        // granted master withdraws mid-transfer
        m0_valid = 0; m1_valid = 0; m1_wstrb = 0;
        #1 chk("drop_ready", 32'(m0_ready), 0);
        step();
        chk("drop_done", 32'(s_valid), 0);
        chk("drop_terr", 32'(timeout_err), 0);
        step();

        // full timeout on m0, then clear
        m0_valid = 1; m0_addr = 32'h0300_0040;
        step();
        repeat (62) step();
        chk("to_63_ready", 32'(m0_ready), 0);
        step();
        chk("to_64_ready", 32'(m0_ready), 1);
        chk("to_64_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_64_terr", 32'(timeout_err), 0);
        step();
        chk("to_terr_set", 32'(timeout_err), 1);
        chk("to_done_ready", 32'(m0_ready), 0);
        m0_valid = 0; err_clr = 1;
        step();
        err_clr = 0;
        chk("to_terr_clr", 32'(timeout_err), 0);

        // slave ack in the timeout cycle completes normally
        m0_valid = 1;
        step();
        repeat (63) step();
        s_ready = 1; s_rdata = 32'h0000_55AA;
        #1 chk("edge_ready", 32'(m0_ready), 1);
        chk("edge_rdata", m0_rdata, 32'h0000_55AA);
        step();
        s_ready = 0; m0_valid = 0;
        chk("edge_terr", 32'(timeout_err), 0);
        step();

        // timeout on m1 coincident with err_clr: set wins
        m1_valid = 1; m1_addr = 32'h0300_0080;
        step();
        repeat (63) step();
        err_clr = 1;
        #1 chk("setwin_m1_ready", 32'(m1_ready), 1);
        chk("setwin_rdata", m1_rdata, 32'hDEAD_BEEF);
        chk("setwin_m0_ready", 32'(m0_ready), 0);
        step();
        err_clr = 0; m1_valid = 0;
        chk("setwin_terr", 32'(timeout_err), 1);
        step();

        // reset in the middle of an m1 write
        m1_valid = 1; m1_wstrb = 4'hF; m1_wdata = 32'h1234_5678;
        step();
        chk("wr_svalid", 32'(s_valid), 1);
        chk("wr_wdata", s_wdata, 32'h1234_5678);
        step();
        resetn = 0; s_ready = 1;
        #1 chk("rstmid_svalid", 32'(s_valid), 0);
        chk("rstmid_m1_ready", 32'(m1_ready), 0);
        step();
        resetn = 1; s_ready = 0;
        #1 chk("postrst_svalid", 32'(s_valid), 0);
        chk("postrst_m1_ready", 32'(m1_ready), 0);
        chk("postrst_terr", 32'(timeout_err), 0);
        step();
        chk("regrant_svalid", 32'(s_valid), 1);
        m1_valid = 0;
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: slave cycles allowed per transfer before forced completion (legal range 2..255).
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on a timed-out transfer.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 m0_valid / m1_valid  input  1  master request (m0 = CPU iomem port, m1 = secondary master).
REQ-006 m0_wstrb / m1_wstrb  input  4  byte write strobes; all zero = read.
REQ-007 m0_addr / m1_addr  input  32  byte address.
REQ-008 m0_wdata / m1_wdata  input  32  write data.
REQ-009 m0_ready / m1_ready  output  1  single-cycle completion pulse to the master.
REQ-010 m0_rdata / m1_rdata  output  32  read data, valid while the matching ready is high.
REQ-011 s_valid  output  1  request to the shared iomem slave.
REQ-012 s_wstrb / s_addr / s_wdata  output  4/32/32  forwarded request fields.
REQ-013 s_ready  input  1  slave completion.
REQ-014 s_rdata  input  32  slave read data.
REQ-015 timeout_err  output  1  sticky flag: a transfer has timed out.
REQ-016 err_clr  input  1  clears timeout_err.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-018 IDLE: if any mx_valid is high, the FSM SHALL latch the winner into grant and go to BUSY on the next edge; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: if both requests are valid, the master not served last wins; after reset, m0 wins the first tie.
REQ-020 BUSY: s_valid SHALL be 1, and s_wstrb, s_addr and s_wdata SHALL combinationally follow the granted master.
REQ-021 BUSY with s_ready=1: the granted mx_ready SHALL be 1 in that same cycle, with mx_rdata=s_rdata; the next state SHALL be DONE.
REQ-022 DONE SHALL last exactly one cycle with s_valid=0 and both ready outputs 0, then return to IDLE; this keeps a valid that is still high from being re-granted as a duplicate.
REQ-023 The wait counter SHALL clear on entry to BUSY and increment each BUSY cycle while s_ready=0.
REQ-024 Timeout: in the BUSY cycle where the counter equals TIMEOUT_CYCLES-1 and s_ready=0, the arbiter SHALL pulse the granted mx_ready with mx_rdata=ERR_DATA, set timeout_err and go to DONE.
REQ-025 If s_ready=1 in the timeout cycle, the completion SHALL be normal: slave data returned, timeout_err unchanged.
REQ-026 If the granted master drops valid while in BUSY, the FSM SHALL go to DONE with no ready pulse and no error.
REQ-027 The non-granted master's ready SHALL be 0 in every cycle; its rdata SHALL be 0 whenever its ready is 0.
REQ-028 If err_clr and a timeout occur in the same cycle, set SHALL win.
REQ-029 Worst-case latency from valid to ready SHALL be 1 (arbitration) + slave latency; a losing master waits at most one further transfer plus 2 cycles.

Reset
REQ-030 With resetn=0 at an edge, the FSM SHALL go to IDLE, clear the counter and timeout_err, and set the last-served pointer to m1.
REQ-031 During reset, s_valid, m0_ready and m1_ready SHALL be 0; a reset in mid-transfer SHALL abort it with no ready pulse.

Structure
REQ-032 The state encodings, ERR_DATA default and bus widths SHALL live in a shared picosoc_iomem_pkg package/header.
REQ-033 The timeout counter SHALL be one sub-module, iomem_watchdog, with inputs start, tick and ack and output expire.

Verification
REQ-034 m0 reads addr 0x0300_0000; slave ready after 3 cycles with 0x0000_00A5 -> m0_ready one pulse, m0_rdata=0x0000_00A5, then one DONE cycle.
REQ-035 m0 and m1 both valid at the same cycle after reset -> m0 served first, m1 next, and the following tie goes to m0.
REQ-036 Slave never readies, TIMEOUT_CYCLES=64 -> granted ready pulses on the 64th BUSY cycle with rdata 0xDEAD_BEEF and timeout_err=1; err_clr pulse -> timeout_err=0.
REQ-037 s_ready=1 exactly in the timeout cycle -> slave data returned and timeout_err stays 0; err_clr coincident with a timeout -> timeout_err=1.
REQ-038 m1 writes 0x1234_5678, wstrb=4'hF, and resetn pulses low mid-BUSY -> no m1_ready, s_valid=0 the following cycle, FSM in IDLE.
